csp1_seq: RTL and testbench

CSP1_SEQ -- requirements
Module: csp1_seq

---
 rtl/csp_pkg.sv | 27 ++
 rtl/csp_cat_buf.sv | 30 +++
 rtl/csp1_seq.sv | 201 ++++++++++++++++++++
 tb/tb_csp1_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csp_pkg.sv
// Shared definitions for the CSP1 sequencer: engine op codes, FSM states and
// the buffer address-width helper.
package csp_pkg;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CBS1 = 3'd1,
    OP_RES  = 3'd2,
    OP_CBS2 = 3'd3,
    OP_CBSO = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CBS1 = 3'd1,
    S_RES  = 3'd2,
    S_CBS2 = 3'd3,
    S_CBSO = 3'd4,
    S_DONE = 3'd5
  } state_t;

  // Address bits for a buffer of 'words' entries, never less than one bit.
  function automatic int addr_width(input int words);
    return (words <= 2) ? 1 : $clog2(words);
  endfunction

endpackage

// File: rtl/csp_cat_buf.sv
// Concatenation store: one write port, one read port, registered read data
// that holds its value whenever no read is issued.
module csp_cat_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is cleared; array contents are left as they are.
  always_ff @(posedge clk) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/csp1_seq.sv
// CSP1 pass sequencer: runs CBS1, N_RES residual iterations, CBS2, then streams
// the channel concatenation {res, cbs2} to the CBSO engine.
module csp1_seq
  import csp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N_RES      = 1,
  parameter int RES_WORDS  = 8,
  parameter int CBS2_WORDS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  eng_start,
  output logic [2:0]            eng_op,
  output logic [2:0]            eng_iter,
  input  logic                  eng_done,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  err
);

  localparam int TOTAL = RES_WORDS + CBS2_WORDS;
  localparam int AW    = addr_width(TOTAL);
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] RES_CNT   = CW'(RES_WORDS);
  localparam logic [CW-1:0] CBS2_CNT  = CW'(CBS2_WORDS);
  localparam logic [CW-1:0] LAST_TX   = CW'(TOTAL - 1);
  localparam logic [2:0]    LAST_ITER = 3'(N_RES - 1);

  state_t        state, state_nx;
  logic [2:0]    iter_q, iter_nx;
  logic [CW-1:0] wr_cnt_q, wr_cnt_nx;
  logic [CW-1:0] tx_cnt_q, tx_cnt_nx;
  logic          eng_start_q, eng_start_nx;
  logic          err_q, err_nx;
  logic          out_valid_q, out_valid_nx;
  logic          eng_seen_q, eng_seen_nx;
  logic          words_done_q, words_done_nx;

  logic          final_res, in_region, accept, xfer, last_xfer;
  logic [CW-1:0] region_size, cnt_after;
  logic          rd_en;
  logic [AW-1:0] wr_addr, rd_addr;

  // Write-side decode: only the final residual iteration and CBS2 own a region.
  always_comb begin
    final_res   = (state == S_RES) && (iter_q == LAST_ITER);
    in_region   = final_res || (state == S_CBS2);
    region_size = (state == S_CBS2) ? CBS2_CNT : RES_CNT;
    in_ready    = in_region && (wr_cnt_q < region_size);
    accept      = in_ready && in_valid;
    cnt_after   = wr_cnt_q + CW'(accept);
    wr_addr     = (state == S_CBS2) ? (AW'(RES_WORDS) + AW'(wr_cnt_q)) : AW'(wr_cnt_q);
    xfer        = out_valid_q && out_ready;
    last_xfer   = xfer && (tx_cnt_q == LAST_TX);
  end

  always_comb begin
    state_nx      = state;
    iter_nx       = iter_q;
    wr_cnt_nx     = cnt_after;
    tx_cnt_nx     = tx_cnt_q;
    eng_start_nx  = 1'b0;
    err_nx        = err_q;
    out_valid_nx  = out_valid_q;
    eng_seen_nx   = eng_seen_q;
    words_done_nx = words_done_q;
    rd_en         = 1'b0;
    rd_addr       = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx     = S_CBS1;
          err_nx       = 1'b0;
          iter_nx      = 3'd0;
          wr_cnt_nx    = '0;
          eng_start_nx = 1'b1;
        end
      end
      S_CBS1: begin
        if (eng_done) begin
          state_nx     = S_RES;
          iter_nx      = 3'd0;
          wr_cnt_nx    = '0;
          eng_start_nx = 1'b1;
        end
      end
      S_RES: begin
        if (eng_done) begin
          eng_start_nx = 1'b1;
          wr_cnt_nx    = '0;
          if (final_res) begin
            if (cnt_after != RES_CNT) err_nx = 1'b1;
            state_nx = S_CBS2;
          end else begin
            iter_nx = iter_q + 3'd1;
          end
        end
      end
      S_CBS2: begin
        // Prefetch word 0 on the way out so out_data is valid on CBSO entry.
        if (eng_done) begin
          if (cnt_after != CBS2_CNT) err_nx = 1'b1;
          state_nx      = S_CBSO;
          eng_start_nx  = 1'b1;
          wr_cnt_nx     = '0;
          tx_cnt_nx     = '0;
          out_valid_nx  = 1'b1;
          eng_seen_nx   = 1'b0;
          words_done_nx = 1'b0;
          rd_en         = 1'b1;
          rd_addr       = '0;
        end
      end
      S_CBSO: begin
        if (eng_done) eng_seen_nx = 1'b1;
        if (xfer) begin
          tx_cnt_nx = tx_cnt_q + CW'(1);
          if (last_xfer) begin
            out_valid_nx  = 1'b0;
            words_done_nx = 1'b1;
          end else begin
            rd_en   = 1'b1;
            rd_addr = AW'(tx_cnt_q + CW'(1));
          end
        end
        if ((words_done_q || last_xfer) && (eng_seen_q || eng_done)) state_nx = S_DONE;
      end
      S_DONE: begin
        state_nx = S_IDLE;
        iter_nx  = 3'd0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      iter_q       <= 3'd0;
      wr_cnt_q     <= '0;
      tx_cnt_q     <= '0;
      eng_start_q  <= 1'b0;
      err_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      eng_seen_q   <= 1'b0;
      words_done_q <= 1'b0;
    end else begin
      state        <= state_nx;
      iter_q       <= iter_nx;
      wr_cnt_q     <= wr_cnt_nx;
      tx_cnt_q     <= tx_cnt_nx;
      eng_start_q  <= eng_start_nx;
      err_q        <= err_nx;
      out_valid_q  <= out_valid_nx;
      eng_seen_q   <= eng_seen_nx;
      words_done_q <= words_done_nx;
    end
  end

  always_comb begin
    case (state)
      S_CBS1:  eng_op = OP_CBS1;
      S_RES:   eng_op = OP_RES;
      S_CBS2:  eng_op = OP_CBS2;
      S_CBSO:  eng_op = OP_CBSO;
      default: eng_op = OP_NONE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign eng_start = eng_start_q;
  assign eng_iter  = iter_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

  csp_cat_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (TOTAL),
    .AW         (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept),
    .wr_addr (wr_addr),
    .wr_data (in_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (out_data)
  );

endmodule

// File: tb/tb_csp1_seq.sv
// Self-checking bench for csp1_seq with a small engine model, a shadow buffer
// and a scoreboard of expected CBSO words and engine ops.
module tb_csp1_seq;

  localparam int DW   = 16;
  localparam int NRES = 2;
  localparam int RW   = 4;
  localparam int CWD  = 4;
  localparam int TOT  = RW + CWD;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, eng_start;
  logic [2:0]    eng_op, eng_iter;
  logic          eng_done = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b1;
  logic          err;

  int tests = 0;
  int fails = 0;
  int xfers = 0;
  int done_cnt = 0;
  bit have_hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic [DW-1:0] model [TOT];
  logic [DW-1:0] exp_q [$];
  logic [2:0]    op_q [$];
  logic [2:0]    it_q [$];

  always #5 clk = ~clk;

  csp1_seq #(
    .DATA_WIDTH (DW),
    .N_RES      (NRES),
    .RES_WORDS  (RW),
    .CBS2_WORDS (CWD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .eng_start (eng_start),
    .eng_op    (eng_op),
    .eng_iter  (eng_iter),
    .eng_done  (eng_done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .err       (err)
  );

  // One clock: scoreboard sampling on the falling edge, then return just after the rising edge.
  task automatic cycle();
    logic [2:0] eop, eit;
    logic [DW-1:0] ed;
    @(negedge clk);
    if (eng_start) begin
      tests++;
      if (op_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL eng_start_unexpected op=%0d", eng_op);
      end else begin
        eop = op_q.pop_front();
        eit = it_q.pop_front();
        if (eng_op !== eop || (eop == 3'd2 && eng_iter !== eit)) begin
          fails++;
          $display("[TB] FAIL eng_op_seq got op=%0d iter=%0d want op=%0d iter=%0d", eng_op, eng_iter, eop, eit);
        end
      end
    end
    if (have_hold) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== hold_data) begin
        fails++;
        $display("[TB] FAIL out_stall_hold got v=%b d=%h want v=1 d=%h", out_valid, out_data, hold_data);
      end
    end
    if (out_valid && out_ready) begin
      tests++;
      xfers++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL out_extra_word got %h want none", out_data);
      end else begin
        ed = exp_q.pop_front();
        if (out_data !== ed) begin
          fails++;
          $display("[TB] FAIL out_data got %h want %h", out_data, ed);
        end
      end
    end
    have_hold = out_valid && !out_ready;
    hold_data = out_data;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_words(input int n, input int region, input logic [DW-1:0] base,
                            input int addr_base, input bit done_on_last);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = base + DW'(i);
      eng_done = done_on_last && (i == n - 1);
      tests++;
      if (in_ready !== ((i < region) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("[TB] FAIL in_ready word=%0d got %b want %b", i, in_ready, (i < region));
      end
      if (i < region) model[addr_base + i] = base + DW'(i);
      cycle();
    end
    in_valid = 1'b0;
    eng_done = 1'b0;
  endtask

  task automatic junk_word_check(input string tag);
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("[TB] FAIL in_ready_%s got %b want 0", tag, in_ready);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  // Full pass with engine knobs; abort_at >= 0 pulses reset after that many CBSO transfers.
  task automatic run_pass(input int res_n, input int cbs2_n, input logic [DW-1:0] res_base,
                          input logic [DW-1:0] cbs2_base, input bit bp, input bit early,
                          input int abort_at, output int nx);
    int k, x0, d0;
    bit sent;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    nx = 0;
    op_q.push_back(3'd1); it_q.push_back(3'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    junk_word_check("cbs1");
    op_q.push_back(3'd2); it_q.push_back(3'd0);
    eng_done = 1'b1; cycle(); eng_done = 1'b0;
    for (int it = 1; it < NRES; it++) begin
      junk_word_check("res_early");
      op_q.push_back(3'd2); it_q.push_back(3'(it));
      eng_done = 1'b1; cycle(); eng_done = 1'b0;
    end
    feed_words(res_n, RW, res_base, 0, 1'b0);
    op_q.push_back(3'd3); it_q.push_back(3'd0);
    eng_done = 1'b1; cycle(); eng_done = 1'b0;
    op_q.push_back(3'd4); it_q.push_back(3'd0);
    feed_words(cbs2_n, CWD, cbs2_base, RW, 1'b1);
    for (int i = 0; i < TOT; i++) exp_q.push_back(model[i]);
    x0 = xfers; d0 = done_cnt; sent = 1'b0; k = 0;
    while (done_cnt == d0 && k < 200) begin
      if (abort_at >= 0 && (xfers - x0) == abort_at) begin
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        nx = xfers - x0;
        exp_q.delete(); op_q.delete(); it_q.delete();
        have_hold = 1'b0;
        out_ready = 1'b1;
        return;
      end
      out_ready = bp ? pat[k % 4] : 1'b1;
      eng_done  = 1'b0;
      if (!sent && (early || (xfers - x0) >= TOT)) begin
        eng_done = 1'b1;
        sent = 1'b1;
      end
      cycle();
      k++;
    end
    eng_done  = 1'b0;
    out_ready = 1'b1;
    nx = xfers - x0;
    tests++;
    if (k >= 200) begin
      fails++;
      $display("[TB] FAIL pass_timeout got no done after %0d cycles want done", k);
    end
  endtask

  task automatic check_pass_end(input string tag, input int nx, input int d0, input bit want_err);
    tests++;
    if (nx != TOT) begin fails++; $display("[TB] FAIL %s_xfers got %0d want %0d", tag, nx, TOT); end
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("[TB] FAIL %s_done_count got %0d want 1", tag, done_cnt - d0); end
    tests++;
    if (err !== want_err) begin fails++; $display("[TB] FAIL %s_err got %b want %b", tag, err, want_err); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL %s_busy_after got %b want 0", tag, busy); end
    tests++;
    if (exp_q.size() != 0 || op_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL %s_leftover got words=%0d ops=%0d want 0", tag, exp_q.size(), op_q.size());
    end
    cycle(); cycle();
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("[TB] FAIL %s_extra_done got %0d want 1", tag, done_cnt - d0); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cycle(); cycle();
    tests++;
    if ({busy, done, eng_start, eng_op, eng_iter, in_ready, out_valid, out_data, err} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_outputs got busy=%b done=%b es=%b op=%0d it=%0d ir=%b ov=%b od=%h err=%b want all 0",
               busy, done, eng_start, eng_op, eng_iter, in_ready, out_valid, out_data, err);
    end
    reset = 1'b1;
    cycle();
  endtask

  task automatic test_nominal();
    int nx, d0;
    d0 = done_cnt;
    run_pass(RW, CWD, 16'h3C00, 16'h3C04, 1'b0, 1'b0, -1, nx);
    check_pass_end("nominal", nx, d0, 1'b0);
  endtask

  task automatic test_backpressure();
    int nx, d0;
    d0 = done_cnt;
    run_pass(RW, CWD, 16'h4100, 16'h4200, 1'b1, 1'b0, -1, nx);
    check_pass_end("backpressure", nx, d0, 1'b0);
  endtask

  task automatic test_overflow();
    int nx, d0;
    d0 = done_cnt;
    run_pass(6, CWD, 16'h5000, 16'h5100, 1'b0, 1'b0, -1, nx);
    check_pass_end("overflow", nx, d0, 1'b0);
  endtask

  task automatic test_short_region();
    int nx, d0;
    d0 = done_cnt;
    run_pass(RW, 3, 16'h6000, 16'h6100, 1'b0, 1'b0, -1, nx);
    check_pass_end("short", nx, d0, 1'b1);
    op_q.push_back(3'd1); it_q.push_back(3'd0);
    start = 1'b1;
    cycle();
    start = 1'b0;
    tests++;
    if (err !== 1'b0) begin fails++; $display("[TB] FAIL short_err_clear got %b want 0", err); end
    op_q.push_back(3'd2); it_q.push_back(3'd0);
    eng_done = 1'b1; cycle(); eng_done = 1'b0;
    reset = 1'b0; cycle(); reset = 1'b1;
    op_q.delete(); it_q.delete();
  endtask

  task automatic test_early_done();
    int nx, d0;
    d0 = done_cnt;
    run_pass(RW, CWD, 16'h7000, 16'h7100, 1'b1, 1'b1, -1, nx);
    check_pass_end("early", nx, d0, 1'b0);
  endtask

  task automatic test_reset_mid_cbso();
    int nx, d0;
    d0 = done_cnt;
    run_pass(RW, CWD, 16'h2000, 16'h2100, 1'b1, 1'b0, 3, nx);
    tests++;
    if ({busy, done, eng_start, eng_op, eng_iter, in_ready, out_valid, out_data, err} !== '0) begin
      fails++;
      $display("[TB] FAIL midreset_outputs got busy=%b done=%b es=%b op=%0d it=%0d ir=%b ov=%b od=%h err=%b want all 0",
               busy, done, eng_start, eng_op, eng_iter, in_ready, out_valid, out_data, err);
    end
    cycle(); cycle(); cycle();
    tests++;
    if (done_cnt != d0) begin fails++; $display("[TB] FAIL midreset_no_done got %0d want %0d", done_cnt, d0); end
    d0 = done_cnt;
    run_pass(RW, CWD, 16'h3C00, 16'h3C04, 1'b0, 1'b0, -1, nx);
    check_pass_end("after_reset", nx, d0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int nx, d0;
    d0 = done_cnt;
    run_pass(RW, CWD, 16'h1000, 16'h1100, 1'b0, 1'b0, -1, nx);
    run_pass(RW, CWD, 16'h1200, 16'h1300, 1'b1, 1'b0, -1, nx);
    tests++;
    if (done_cnt - d0 != 2) begin fails++; $display("[TB] FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
    check_pass_end("b2b", nx, d0 + 1, 1'b0);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_backpressure();
    test_overflow();
    test_short_region();
    test_early_done();
    test_reset_mid_cbso();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
